csr_access_ctrl: RTL and testbench

//  Sequences every access to the 4096-entry CSR file over its single read/write port.

---
 rtl/csr_pkg.sv | 34 +++
 rtl/csr_rmw_alu.sv | 38 +++
 rtl/csr_access_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access controller: CSR addresses, Zicsr funct3
// encodings, mstatus bit positions and the controller state type.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    IDLE, C_RD, C_WR,
    T_EPC, T_CAUSE, T_TVAL, T_STAT, T_VEC,
    M_STAT, M_EPC
  } state_t;

  // funct3 x00 (ecall/ebreak group and reserved) is not a CSR operation
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    return f3[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write datapath for Zicsr operations: produces the
// new CSR value and whether the CSR file is actually written.
module csr_rmw_alu
  import csr_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] old_val,
  input  logic [31:0] src,
  input  logic [4:0]  rs1_idx,
  output logic [31:0] new_val,
  output logic        write_en
);

  // Set/clear forms with rs1/zimm field 0 must not write (side-effect free reads)
  always_comb begin
    new_val  = old_val;
    write_en = 1'b0;
    case (funct3[1:0])
      2'b01: begin
        new_val  = src;
        write_en = 1'b1;
      end
      2'b10: begin
        new_val  = old_val | src;
        write_en = (rs1_idx != 5'd0);
      end
      2'b11: begin
        new_val  = old_val & ~src;
        write_en = (rs1_idx != 5'd0);
      end
      default: begin
        new_val  = old_val;
        write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences all accesses to the CSR file over its single port: Zicsr RMW,
// trap entry and mret, arbitrated trap > mret > instruction.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [1:0]  TRAP_MPP = 2'b11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs1_val,
  output logic            instr_ready,
  output logic            instr_done,
  output logic [XLEN-1:0] instr_rdata,
  output logic            instr_illegal,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  output logic            trap_ack,
  output logic [XLEN-1:0] trap_vector,
  input  logic            mret_req,
  output logic            mret_ack,
  output logic [XLEN-1:0] mret_pc,
  output logic [3:0]      csr_ctrl,
  output logic [XLEN-1:0] csr_instr,
  output logic [XLEN-1:0] csr_wd,
  input  logic [XLEN-1:0] csr_rd
);

  state_t            state_q, state_d;
  logic [19:0]       instr_q, instr_d;   // instr[31:12]: addr, rs1/zimm, funct3
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   old_q, old_d;

  logic [11:0]       cap_addr;
  logic [4:0]        cap_rs1;
  logic [2:0]        cap_f3;
  logic [XLEN-1:0]   src;
  logic [XLEN-1:0]   alu_new;
  logic              alu_we;
  logic [11:0]       csr_addr;
  logic [XLEN-1:0]   stat_trap;
  logic [XLEN-1:0]   stat_mret;

  assign cap_addr = instr_q[19:8];
  assign cap_rs1  = instr_q[7:3];
  assign cap_f3   = instr_q[2:0];
  assign src      = cap_f3[2] ? {27'b0, cap_rs1} : rs1_q;

  csr_rmw_alu u_alu (
    .funct3   (cap_f3),
    .old_val  (old_q),
    .src      (src),
    .rs1_idx  (cap_rs1),
    .new_val  (alu_new),
    .write_en (alu_we)
  );

  assign instr_ready = rst_n && (state_q == IDLE) && !trap_req && !mret_req;

  // Address decode depends on state only, keeping csr_rd -> csr_wd free of loops
  always_comb begin
    csr_addr = '0;
    case (state_q)
      C_RD, C_WR:     csr_addr = cap_addr;
      T_EPC, M_EPC:   csr_addr = CSR_MEPC;
      T_CAUSE:        csr_addr = CSR_MCAUSE;
      T_TVAL:         csr_addr = CSR_MTVAL;
      T_STAT, M_STAT: csr_addr = CSR_MSTATUS;
      T_VEC:          csr_addr = CSR_MTVEC;
      default:        csr_addr = '0;
    endcase
  end

  assign csr_instr = {csr_addr, 20'b0};

  always_comb begin
    stat_trap = csr_rd;
    stat_trap[MSTATUS_MPIE] = csr_rd[MSTATUS_MIE];
    stat_trap[MSTATUS_MIE]  = 1'b0;
    stat_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = TRAP_MPP;

    stat_mret = csr_rd;
    stat_mret[MSTATUS_MIE]  = csr_rd[MSTATUS_MPIE];
    stat_mret[MSTATUS_MPIE] = 1'b1;
    stat_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    rs1_d         = rs1_q;
    old_d         = old_q;
    instr_done    = 1'b0;
    instr_rdata   = '0;
    instr_illegal = 1'b0;
    trap_ack      = 1'b0;
    trap_vector   = '0;
    mret_ack      = 1'b0;
    mret_pc       = '0;
    csr_ctrl      = '0;
    csr_wd        = '0;

    case (state_q)
      IDLE: begin
        if (trap_req) begin
          state_d = T_EPC;
        end else if (mret_req) begin
          state_d = M_STAT;
        end else if (instr_valid) begin
          state_d = C_RD;
          instr_d = instr[31:12];
          rs1_d   = rs1_val;
        end
      end
      C_RD: begin
        csr_ctrl = {1'b0, cap_f3};
        old_d    = csr_rd;
        if (f3_is_illegal(cap_f3)) begin
          instr_done    = 1'b1;
          instr_illegal = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = C_WR;
        end
      end
      C_WR: begin
        csr_ctrl    = {alu_we, cap_f3};
        csr_wd      = alu_new;
        instr_done  = 1'b1;
        instr_rdata = old_q;
        state_d     = IDLE;
      end
      T_EPC: begin
        csr_ctrl = {1'b1, F3_CSRRW};
        csr_wd   = trap_pc;
        state_d  = T_CAUSE;
      end
      T_CAUSE: begin
        csr_ctrl = {1'b1, F3_CSRRW};
        csr_wd   = trap_cause;
        state_d  = T_TVAL;
      end
      T_TVAL: begin
        csr_ctrl = {1'b1, F3_CSRRW};
        csr_wd   = trap_tval;
        state_d  = T_STAT;
      end
      T_STAT: begin
        csr_ctrl = {1'b1, F3_CSRRW};
        csr_wd   = stat_trap;
        state_d  = T_VEC;
      end
      T_VEC: begin
        trap_ack    = 1'b1;
        trap_vector = {csr_rd[XLEN-1:2], 2'b00};
        state_d     = IDLE;
      end
      M_STAT: begin
        csr_ctrl = {1'b1, F3_CSRRW};
        csr_wd   = stat_mret;
        state_d  = M_EPC;
      end
      M_EPC: begin
        mret_ack = 1'b1;
        mret_pc  = csr_rd;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      rs1_q   <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rs1_q   <= rs1_d;
      old_q   <= old_d;
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl with a 4096-entry CSR file and a reference model of
// CSR contents built from the Zicsr/trap/mret rules.
module tb_csr_access_ctrl;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rs1_val = '0;
  logic        instr_ready, instr_done, instr_illegal;
  logic [31:0] instr_rdata;
  logic        trap_req = 1'b0;
  logic [31:0] trap_pc = '0, trap_cause = '0, trap_tval = '0;
  logic        trap_ack;
  logic [31:0] trap_vector;
  logic        mret_req = 1'b0;
  logic        mret_ack;
  logic [31:0] mret_pc;
  logic [3:0]  csr_ctrl;
  logic [31:0] csr_instr, csr_wd, csr_rd;

  int checks = 0;
  int failures = 0;

  logic        clear_file = 1'b1;
  logic [31:0] csr_file [4096];
  logic [31:0] ref_csr  [4096];

  always #5 clk = ~clk;

  csr_access_ctrl #(.XLEN(32), .TRAP_MPP(2'b11)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .rs1_val(rs1_val),
    .instr_ready(instr_ready), .instr_done(instr_done),
    .instr_rdata(instr_rdata), .instr_illegal(instr_illegal),
    .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_tval(trap_tval), .trap_ack(trap_ack), .trap_vector(trap_vector),
    .mret_req(mret_req), .mret_ack(mret_ack), .mret_pc(mret_pc),
    .csr_ctrl(csr_ctrl), .csr_instr(csr_instr), .csr_wd(csr_wd), .csr_rd(csr_rd)
  );

  assign csr_rd = csr_file[csr_instr[31:20]];

  always @(posedge clk) begin
    if (clear_file) begin
      for (int i = 0; i < 4096; i++) csr_file[i] <= '0;
    end else if (csr_ctrl[3]) begin
      csr_file[csr_instr[31:20]] <= csr_wd;
    end
  end

  function automatic logic [31:0] model_trap_status(input logic [31:0] st);
    return (st & ~32'h0000_1888) | (st[3] ? 32'h0000_0080 : 32'h0) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] model_mret_status(input logic [31:0] st);
    return (st & ~32'h0000_1888) | (st[7] ? 32'h0000_0008 : 32'h0) | 32'h0000_0080;
  endfunction

  function automatic logic [31:0] model_new(input logic [2:0] f3, input logic [31:0] old,
                                            input logic [4:0] rs1f, input logic [31:0] rv);
    logic [31:0] opnd;
    opnd = f3[2] ? {27'd0, rs1f} : rv;
    if (f3 == 3'd1 || f3 == 3'd5) return opnd;
    if (f3 == 3'd2 || f3 == 3'd6) return old | opnd;
    return old & ~opnd;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    clear_file = 1'b1;
    for (int i = 0; i < 4096; i++) ref_csr[i] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({instr_ready, instr_done, instr_rdata, instr_illegal, trap_ack, trap_vector,
         mret_ack, mret_pc, csr_ctrl, csr_instr, csr_wd} !== '0)
      begin $display("FAIL reset_outputs: ready=%b done=%b ctrl=%h instr=%h wd=%h required all 0",
                     instr_ready, instr_done, csr_ctrl, csr_instr, csr_wd); failures++; end
    clear_file = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1)
      begin $display("FAIL reset_ready_idle: got %b required 1", instr_ready); failures++; end
  endtask

  task automatic do_instr(input logic [2:0] f3, input logic [11:0] addr,
                          input logic [4:0] rs1f, input logic [31:0] rv);
    int n;
    bit got, we_seen, legal, exp_we;
    logic [31:0] exp_old, exp_new;
    legal   = (f3[1:0] != 2'b00);
    exp_old = ref_csr[addr];
    exp_new = model_new(f3, exp_old, rs1f, rv);
    exp_we  = legal && (f3[1:0] == 2'b01 || rs1f != 5'd0);
    @(negedge clk);
    instr = {addr, rs1f, f3, 5'd1, 7'h73};
    rs1_val = rv;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!instr_ready) begin
      $display("FAIL accept_timeout: instr_ready=%b required 1", instr_ready);
      failures++; instr_valid = 1'b0; return;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom;
    rs1_val = $urandom;
    n = 1; got = 0; we_seen = 0;
    while (n <= 10) begin
      if (csr_ctrl[3]) we_seen = 1;
      if (instr_done) begin got = 1; break; end
      @(negedge clk); n++;
    end
    checks++;
    if (!got || n != (legal ? 2 : 1))
      begin $display("FAIL instr_latency f3=%0d: got %0d cycles (seen=%0b) required %0d",
                     f3, n, got, legal ? 2 : 1); failures++; end
    checks++;
    if (instr_illegal !== !legal)
      begin $display("FAIL instr_illegal f3=%0d: got %b required %b", f3, instr_illegal, !legal); failures++; end
    if (legal) begin
      checks++;
      if (instr_rdata !== exp_old)
        begin $display("FAIL instr_rdata addr=%h: got %h required %h", addr, instr_rdata, exp_old); failures++; end
    end
    checks++;
    if (we_seen != exp_we)
      begin $display("FAIL write_enable f3=%0d rs1=%0d: got %b required %b", f3, rs1f, we_seen, exp_we); failures++; end
    if (exp_we) ref_csr[addr] = exp_new;
    @(negedge clk);
    checks++;
    if (csr_file[addr] !== ref_csr[addr])
      begin $display("FAIL csr_value addr=%h: got %h required %h", addr, csr_file[addr], ref_csr[addr]); failures++; end
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
    int n;
    bit got;
    logic [11:0] al [4];
    al = '{A_MEPC, A_MCAUSE, A_MTVAL, A_MSTATUS};
    @(negedge clk);
    trap_pc = pc; trap_cause = cause; trap_tval = tval; trap_req = 1'b1;
    n = 0; got = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (trap_ack) begin got = 1; break; end
    end
    checks++;
    if (!got || n != 5)
      begin $display("FAIL trap_latency: got %0d cycles (seen=%0b) required 5", n, got); failures++; end
    checks++;
    if (trap_vector !== {ref_csr[A_MTVEC][31:2], 2'b00})
      begin $display("FAIL trap_vector: got %h required %h", trap_vector,
                     {ref_csr[A_MTVEC][31:2], 2'b00}); failures++; end
    trap_req = 1'b0;
    ref_csr[A_MEPC]    = pc;
    ref_csr[A_MCAUSE]  = cause;
    ref_csr[A_MTVAL]   = tval;
    ref_csr[A_MSTATUS] = model_trap_status(ref_csr[A_MSTATUS]);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (csr_file[al[i]] !== ref_csr[al[i]])
        begin $display("FAIL trap_csr addr=%h: got %h required %h", al[i], csr_file[al[i]], ref_csr[al[i]]); failures++; end
    end
  endtask

  task automatic do_mret();
    int n;
    bit got;
    @(negedge clk);
    mret_req = 1'b1;
    n = 0; got = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (mret_ack) begin got = 1; break; end
    end
    checks++;
    if (!got || n != 2)
      begin $display("FAIL mret_latency: got %0d cycles (seen=%0b) required 2", n, got); failures++; end
    checks++;
    if (mret_pc !== ref_csr[A_MEPC])
      begin $display("FAIL mret_pc: got %h required %h", mret_pc, ref_csr[A_MEPC]); failures++; end
    mret_req = 1'b0;
    ref_csr[A_MSTATUS] = model_mret_status(ref_csr[A_MSTATUS]);
    @(negedge clk);
    checks++;
    if (csr_file[A_MSTATUS] !== ref_csr[A_MSTATUS])
      begin $display("FAIL mret_mstatus: got %h required %h", csr_file[A_MSTATUS], ref_csr[A_MSTATUS]); failures++; end
  endtask

  task automatic test_rw();
    do_instr(3'b001, 12'h340, 5'd1, 32'h1234_5678);
    do_instr(3'b001, 12'h340, 5'd2, 32'hDEAD_BEEF);
    checks++;
    if (csr_file[12'h340] !== 32'hDEAD_BEEF)
      begin $display("FAIL rw_mscratch: got %h required deadbeef", csr_file[12'h340]); failures++; end
  endtask

  task automatic test_set_clear();
    do_instr(3'b001, 12'h340, 5'd1, 32'h0000_00A5);
    do_instr(3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF);
    do_instr(3'b001, 12'h340, 5'd1, 32'h0000_00FF);
    do_instr(3'b111, 12'h340, 5'd5, 32'h0);
    checks++;
    if (csr_file[12'h340] !== 32'h0000_00FA)
      begin $display("FAIL csrrci_result: got %h required 000000fa", csr_file[12'h340]); failures++; end
  endtask

  task automatic test_trap();
    do_instr(3'b001, A_MSTATUS, 5'd1, 32'h0000_0008);
    do_instr(3'b001, A_MTVEC, 5'd1, 32'h0000_2001);
    do_trap(32'h100, 32'hB, 32'h7);
    checks++;
    if (csr_file[A_MSTATUS] !== 32'h0000_1880)
      begin $display("FAIL trap_mstatus_const: got %h required 00001880", csr_file[A_MSTATUS]); failures++; end
  endtask

  task automatic test_simultaneous();
    int k, t_ack, m_ack, i_done;
    bit acc;
    logic [31:0] rv, exp_old;
    rv = $urandom;
    @(negedge clk);
    trap_pc = 32'h100; trap_cause = 32'h3; trap_tval = 32'h44; trap_req = 1'b1;
    mret_req = 1'b1;
    instr = {12'h7C1, 5'd1, 3'b001, 5'd1, 7'h73}; rs1_val = rv; instr_valid = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b0)
      begin $display("FAIL simul_ready: got %b required 0", instr_ready); failures++; end
    k = 0; t_ack = -1; m_ack = -1; i_done = -1; acc = 0;
    exp_old = ref_csr[12'h7C1];
    while (k < 40 && i_done < 0) begin
      @(negedge clk); k++;
      if (acc) begin instr_valid = 1'b0; acc = 0; end
      if (trap_ack && t_ack < 0) begin
        t_ack = k; trap_req = 1'b0;
        ref_csr[A_MEPC] = 32'h100; ref_csr[A_MCAUSE] = 32'h3; ref_csr[A_MTVAL] = 32'h44;
        ref_csr[A_MSTATUS] = model_trap_status(ref_csr[A_MSTATUS]);
      end
      if (mret_ack && m_ack < 0) begin
        m_ack = k; mret_req = 1'b0;
        checks++;
        if (mret_pc !== 32'h100)
          begin $display("FAIL simul_mret_pc: got %h required 00000100", mret_pc); failures++; end
        ref_csr[A_MSTATUS] = model_mret_status(ref_csr[A_MSTATUS]);
      end
      if (instr_done && i_done < 0) begin
        i_done = k;
        checks++;
        if (instr_rdata !== exp_old)
          begin $display("FAIL simul_rdata: got %h required %h", instr_rdata, exp_old); failures++; end
        ref_csr[12'h7C1] = rv;
      end
      if (instr_valid && instr_ready) acc = 1;
    end
    instr_valid = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
    checks++;
    if (!(t_ack == 5 && m_ack > t_ack && i_done > m_ack))
      begin $display("FAIL simul_order: trap@%0d mret@%0d instr@%0d required trap@5 < mret < instr",
                     t_ack, m_ack, i_done); failures++; end
    @(negedge clk);
    checks++;
    if (csr_file[A_MSTATUS] !== 32'h0000_0080 || ref_csr[A_MSTATUS] !== 32'h0000_0080)
      begin $display("FAIL simul_mstatus: got %h required 00000080", csr_file[A_MSTATUS]); failures++; end
    checks++;
    if (csr_file[12'h7C1] !== ref_csr[12'h7C1])
      begin $display("FAIL simul_instr_write: got %h required %h", csr_file[12'h7C1], ref_csr[12'h7C1]); failures++; end
  endtask

  task automatic test_illegal();
    do_instr(3'b100, 12'h340, 5'd7, 32'hFFFF_FFFF);
    do_instr(3'b000, 12'h7C0, 5'd3, 32'h5555_5555);
  endtask

  task automatic test_trap_during_instr();
    int k, t_ack, i_done;
    logic [31:0] rv, exp_old;
    rv = $urandom;
    exp_old = ref_csr[12'h7C0];
    @(negedge clk);
    instr = {12'h7C0, 5'd3, 3'b010, 5'd1, 7'h73}; rs1_val = rv; instr_valid = 1'b1;
    k = 0;
    while (!instr_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    instr_valid = 1'b0;
    trap_pc = $urandom; trap_cause = $urandom; trap_tval = $urandom; trap_req = 1'b1;
    k = 1; t_ack = -1; i_done = -1;
    while (k <= 30 && t_ack < 0) begin
      if (instr_done && i_done < 0) begin
        i_done = k;
        checks++;
        if (instr_rdata !== exp_old)
          begin $display("FAIL mid_trap_rdata: got %h required %h", instr_rdata, exp_old); failures++; end
        ref_csr[12'h7C0] = exp_old | rv;
      end
      if (trap_ack) begin
        t_ack = k; trap_req = 1'b0;
        ref_csr[A_MEPC] = trap_pc; ref_csr[A_MCAUSE] = trap_cause; ref_csr[A_MTVAL] = trap_tval;
        ref_csr[A_MSTATUS] = model_trap_status(ref_csr[A_MSTATUS]);
      end else begin
        @(negedge clk); k++;
      end
    end
    trap_req = 1'b0;
    checks++;
    if (i_done != 2 || t_ack != 8)
      begin $display("FAIL mid_trap_order: instr@%0d trap@%0d required instr@2 trap@8", i_done, t_ack); failures++; end
    @(negedge clk);
    checks++;
    if (csr_file[12'h7C0] !== ref_csr[12'h7C0] || csr_file[A_MEPC] !== ref_csr[A_MEPC])
      begin $display("FAIL mid_trap_csrs: got %h/%h required %h/%h", csr_file[12'h7C0], csr_file[A_MEPC],
                     ref_csr[12'h7C0], ref_csr[A_MEPC]); failures++; end
  endtask

  task automatic test_random();
    logic [11:0] pool [4];
    int unsigned r;
    logic [4:0] rs1f;
    pool = '{12'h340, 12'h7C0, 12'h7C1, 12'h305};
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_trap($urandom, $urandom, $urandom);
      end else if (r == 1) begin
        do_mret();
      end else begin
        rs1f = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        do_instr(3'($urandom_range(0, 7)), pool[$urandom_range(0, 3)], rs1f, $urandom);
      end
    end
  endtask

  task automatic test_reset_mid_trap();
    logic [31:0] pc, cause, old_stat;
    pc = $urandom; cause = $urandom;
    old_stat = ref_csr[A_MSTATUS];
    @(negedge clk);
    trap_pc = pc; trap_cause = cause; trap_tval = $urandom; trap_req = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    trap_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_ready, instr_done, instr_rdata, instr_illegal, trap_ack, trap_vector,
         mret_ack, mret_pc, csr_ctrl, csr_instr, csr_wd} !== '0)
      begin $display("FAIL abort_outputs: ctrl=%h instr=%h wd=%h ack=%b required all 0",
                     csr_ctrl, csr_instr, csr_wd, trap_ack); failures++; end
    rst_n = 1'b1;
    ref_csr[A_MEPC] = pc;
    ref_csr[A_MCAUSE] = cause;
    checks++;
    if (csr_file[A_MEPC] !== pc || csr_file[A_MCAUSE] !== cause)
      begin $display("FAIL abort_kept: mepc=%h mcause=%h required %h %h",
                     csr_file[A_MEPC], csr_file[A_MCAUSE], pc, cause); failures++; end
    checks++;
    if (csr_file[A_MSTATUS] !== old_stat)
      begin $display("FAIL abort_mstatus: got %h required %h", csr_file[A_MSTATUS], old_stat); failures++; end
    do_instr(3'b001, 12'h340, 5'd4, 32'hCAFE_F00D);
  endtask

  initial begin
    test_reset();
    test_rw();
    test_set_clear();
    test_trap();
    test_simultaneous();
    test_illegal();
    test_trap_during_instr();
    test_random();
    test_reset_mid_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
